affine_sched_ctrl: RTL and testbench

Parametrised affine schedule controller for the lake memory tiles. It runs a free cycle counter and an N-deep nested loop iterator. The iterator's schedule time is start + Σ idx_i·stride_i. `valid` fires on the cycle where that schedule time equals the cycle counter, and each fire advances the iterator. Compared with the fixed 2-D controller, it adds run-time configuration, clock enable, flush, a done flag, iterator index outputs and missed-schedule detection.

---
 rtl/affine_ctrl_pkg.sv | 36 +++
 rtl/affine_iter_counter.sv | 57 +++++
 rtl/affine_sched_ctrl.sv | 156 +++++++++++++++
 tb/tb_affine_sched_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/affine_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : affine_ctrl_pkg
// Brief    : Shared defaults, config bundle and field helper for the affine
//            schedule controller.
// Revision : 1.0
// ============================================================================
package affine_ctrl_pkg;

    localparam int MAX_DIMS    = 6;
    localparam int CNT_W_DEF   = 16;
    localparam int TIME_W_DEF  = 16;
    localparam int BUS_MAX_W   = 2048;
    localparam int FIELD_MAX_W = 64;

    typedef struct packed {
        logic [$clog2(MAX_DIMS+1)-1:0]  dims;
        logic [MAX_DIMS*CNT_W_DEF-1:0]  ranges;
        logic [MAX_DIMS*TIME_W_DEF-1:0] strides;
        logic [TIME_W_DEF-1:0]          start;
    } affine_cfg_t;

    // Returns field `dim` of a bus of `width`-bit fields, dim0 in the LSBs.
    function automatic logic [FIELD_MAX_W-1:0] unpack_dim(
        input logic [BUS_MAX_W-1:0] bus,
        input int unsigned          dim,
        input int unsigned          width
    );
        logic [BUS_MAX_W-1:0] w_shifted;
        w_shifted = bus >> (dim * width);
        return w_shifted[FIELD_MAX_W-1:0]
             & ((FIELD_MAX_W'(1) << width) - FIELD_MAX_W'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/affine_iter_counter.sv
`default_nettype none
// ============================================================================
// Module   : affine_iter_counter
// Brief    : Nested loop index counters with carry chain and last-iteration flag.
// Revision : 1.0
// ============================================================================
module affine_iter_counter #(
    parameter int NUM_DIMS = 6,
    parameter int CNT_W    = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_flush,
    input  logic                               i_step,
    input  logic [NUM_DIMS-1:0]                i_active,
    input  logic [NUM_DIMS-1:0][CNT_W-1:0]     i_range_m1,
    output logic [NUM_DIMS-1:0][CNT_W-1:0]     o_idx,
    output logic [NUM_DIMS-1:0]                o_inc_onehot,
    output logic [NUM_DIMS-1:0]                o_wrap,
    output logic                               o_last
);

    logic [NUM_DIMS:0]   w_carry;
    logic [NUM_DIMS-1:0] w_at_max;

    assign w_carry[0] = 1'b1;
    assign o_last     = w_carry[NUM_DIMS];

    generate
        for (genvar k = 0; k < NUM_DIMS; k++) begin : g_dim
            logic [CNT_W-1:0] r_idx;

            // Inactive dims look saturated so a carry only reaches them on the final iteration.
            assign w_at_max[k]     = ~i_active[k] | (r_idx == i_range_m1[k]);
            assign w_carry[k+1]    = w_carry[k] & w_at_max[k];
            assign o_inc_onehot[k] = w_carry[k] & ~w_at_max[k];
            assign o_wrap[k]       = w_carry[k] & w_at_max[k];
            assign o_idx[k]        = r_idx;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_idx <= '0;
                end else if (i_flush) begin
                    r_idx <= '0;
                end else if (i_step && !o_last) begin
                    if (o_inc_onehot[k]) begin
                        r_idx <= r_idx + CNT_W'(1);
                    end else if (o_wrap[k]) begin
                        r_idx <= '0;
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/affine_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : affine_sched_ctrl
// Brief    : Run-time configurable N-D affine schedule controller with flush,
//            done and missed-schedule flags.
// Revision : 1.0
// ============================================================================
module affine_sched_ctrl
    import affine_ctrl_pkg::*;
#(
    parameter int NUM_DIMS = MAX_DIMS,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int TIME_W   = TIME_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clk_en,
    input  logic                            flush,
    input  logic [$clog2(NUM_DIMS+1)-1:0]   cfg_dimensionality,
    input  logic [NUM_DIMS*CNT_W-1:0]       cfg_ranges,
    input  logic [NUM_DIMS*TIME_W-1:0]      cfg_strides,
    input  logic [TIME_W-1:0]               cfg_start_time,
    output logic                            valid,
    output logic [TIME_W-1:0]               sched_time,
    output logic [TIME_W-1:0]               cycle_time,
    output logic [NUM_DIMS*CNT_W-1:0]       iter_idx,
    output logic                            done,
    output logic                            sched_miss
);

    localparam int c_dim_w = $clog2(NUM_DIMS+1);

    logic [c_dim_w-1:0]                  w_eff_dims;
    logic [NUM_DIMS-1:0]                 w_active;
    logic [NUM_DIMS-1:0][CNT_W-1:0]      w_range_m1;
    logic [NUM_DIMS-1:0][TIME_W-1:0]     w_stride;
    logic [NUM_DIMS-1:0][TIME_W-1:0]     w_part;
    logic [NUM_DIMS-1:0][CNT_W-1:0]      w_idx;
    logic [NUM_DIMS-1:0]                 w_inc_onehot;
    logic [NUM_DIMS-1:0]                 w_wrap;
    logic                                w_last;
    logic                                w_valid;
    logic [TIME_W-1:0]                   w_sched_time;
    logic [TIME_W-1:0]                   w_delta;

    logic [TIME_W-1:0]                   r_cycle;
    logic [TIME_W-1:0]                   r_offset;
    logic                                r_done;
    logic                                r_miss;
    logic                                r_dup;

    always_comb begin
        if (cfg_dimensionality == '0) begin
            w_eff_dims = c_dim_w'(1);
        end else if (cfg_dimensionality > c_dim_w'(NUM_DIMS)) begin
            w_eff_dims = c_dim_w'(NUM_DIMS);
        end else begin
            w_eff_dims = cfg_dimensionality;
        end
    end

    generate
        for (genvar k = 0; k < NUM_DIMS; k++) begin : g_dim
            logic [CNT_W-1:0]  w_range_raw;
            logic [TIME_W-1:0] r_part;

            assign w_range_raw   = CNT_W'(unpack_dim(BUS_MAX_W'(cfg_ranges), k, CNT_W));
            assign w_range_m1[k] = (w_range_raw == '0) ? '0 : w_range_raw - CNT_W'(1);
            assign w_stride[k]   = TIME_W'(unpack_dim(BUS_MAX_W'(cfg_strides), k, TIME_W));
            assign w_active[k]   = (c_dim_w'(k) < w_eff_dims);
            assign w_part[k]     = r_part;

            // Running stride*idx for this dim, so a wrap can subtract it without a multiply.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_part <= '0;
                end else if (flush) begin
                    r_part <= '0;
                end else if (w_valid && !w_last) begin
                    if (w_inc_onehot[k]) begin
                        r_part <= r_part + w_stride[k];
                    end else if (w_wrap[k]) begin
                        r_part <= '0;
                    end
                end
            end
        end
    endgenerate

    affine_iter_counter #(
        .NUM_DIMS (NUM_DIMS),
        .CNT_W    (CNT_W)
    ) u_iter (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (flush),
        .i_step       (w_valid),
        .i_active     (w_active),
        .i_range_m1   (w_range_m1),
        .o_idx        (w_idx),
        .o_inc_onehot (w_inc_onehot),
        .o_wrap       (w_wrap),
        .o_last       (w_last)
    );

    always_comb begin
        w_delta = '0;
        for (int k = 0; k < NUM_DIMS; k++) begin
            if (w_inc_onehot[k]) w_delta = w_delta + w_stride[k];
            if (w_wrap[k])       w_delta = w_delta - w_part[k];
        end
    end

    assign w_sched_time = cfg_start_time + r_offset;

    // Iterations sharing the slot of the one just issued go out on the following cycles.
    assign w_valid = clk_en & ~flush & ~r_done & ((r_cycle == w_sched_time) | r_dup);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle  <= '0;
            r_offset <= '0;
            r_done   <= 1'b0;
            r_miss   <= 1'b0;
            r_dup    <= 1'b0;
        end else if (flush) begin
            r_cycle  <= '0;
            r_offset <= '0;
            r_done   <= 1'b0;
            r_miss   <= 1'b0;
            r_dup    <= 1'b0;
        end else if (clk_en && !r_done) begin
            r_cycle <= r_cycle + TIME_W'(1);
            if (w_sched_time < r_cycle) begin
                r_miss <= 1'b1;
            end
            if (w_valid) begin
                if (w_last) begin
                    r_done <= 1'b1;
                end else begin
                    r_offset <= r_offset + w_delta;
                    r_dup    <= (w_delta == '0);
                end
            end
        end
    end

    assign valid      = w_valid;
    assign sched_time = w_sched_time;
    assign cycle_time = r_cycle;
    assign iter_idx   = w_idx;
    assign done       = r_done;
    assign sched_miss = r_miss;

endmodule
`default_nettype wire

// File: tb/tb_affine_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_affine_sched_ctrl
// Brief    : Directed and random checks of affine_sched_ctrl against an
//            iteration-list reference model.
// Revision : 1.0
// ============================================================================
module tb_affine_sched_ctrl;
    import affine_ctrl_pkg::*;

    logic        clk, rst_n, clk_en, flush;
    logic [2:0]  cfg_dimensionality;
    logic [95:0] cfg_ranges, cfg_strides;
    logic [15:0] cfg_start_time;
    logic        valid, done, sched_miss;
    logic [15:0] sched_time, cycle_time;
    logic [95:0] iter_idx;

    int n_tests, n_fail;

    // Reference model: ordered list of (time, indices) per iteration plus a cursor.
    logic [15:0] m_t[$];
    logic [95:0] m_ix[$];
    int          m_p;
    logic [15:0] m_c;
    bit          m_done, m_miss;

    affine_sched_ctrl #(.NUM_DIMS(6), .CNT_W(16), .TIME_W(16)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .clk_en             (clk_en),
        .flush              (flush),
        .cfg_dimensionality (cfg_dimensionality),
        .cfg_ranges         (cfg_ranges),
        .cfg_strides        (cfg_strides),
        .cfg_start_time     (cfg_start_time),
        .valid              (valid),
        .sched_time         (sched_time),
        .cycle_time         (cycle_time),
        .iter_idx           (iter_idx),
        .done               (done),
        .sched_miss         (sched_miss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_p = 0; m_c = '0; m_done = 0; m_miss = 0;
    endtask

    task automatic build(input affine_cfg_t cfg);
        int ed, total, rem, i;
        int r[6];
        logic [15:0] t;
        logic [95:0] ix;
        ed = (cfg.dims == 0) ? 1 : ((cfg.dims > 6) ? 6 : int'(cfg.dims));
        total = 1;
        for (int k = 0; k < 6; k++) begin
            r[k] = (k < ed && cfg.ranges[k*16 +: 16] != 0) ? int'(cfg.ranges[k*16 +: 16]) : 1;
            total = total * r[k];
        end
        m_t.delete();
        m_ix.delete();
        for (int n = 0; n < total; n++) begin
            rem = n; t = cfg.start; ix = '0;
            for (int k = 0; k < 6; k++) begin
                i = rem % r[k];
                rem = rem / r[k];
                ix[k*16 +: 16] = 16'(i);
                t = t + 16'(i * int'(cfg.strides[k*16 +: 16]));
            end
            m_t.push_back(t);
            m_ix.push_back(ix);
        end
        cfg_dimensionality = cfg.dims;
        cfg_ranges         = cfg.ranges;
        cfg_strides        = cfg.strides;
        cfg_start_time     = cfg.start;
    endtask

    task automatic cycle(input bit en, input bit fl, output bit v, output logic [15:0] ct,
                         output bit dn, output bit ms);
        bit ev;
        @(negedge clk);
        clk_en = en;
        flush  = fl;
        #1;
        ev = en && !fl && !m_done &&
             ((m_c == m_t[m_p]) || (m_p > 0 && m_t[m_p] == m_t[m_p-1]));
        chk("valid", 96'(valid), 96'(ev));
        if (!fl) begin
            chk("sched_time", 96'(sched_time), 96'(m_t[m_p]));
            chk("cycle_time", 96'(cycle_time), 96'(m_c));
            chk("iter_idx",   iter_idx,        m_ix[m_p]);
            chk("done",       96'(done),       96'(m_done));
            chk("sched_miss", 96'(sched_miss), 96'(m_miss));
        end
        v = valid; ct = cycle_time; dn = done; ms = sched_miss;
        if (fl) begin
            m_reset();
        end else if (en && !m_done) begin
            if (m_t[m_p] < m_c) m_miss = 1;
            if (ev) begin
                if (m_p == m_t.size() - 1) m_done = 1;
                else m_p++;
            end
            m_c = m_c + 16'd1;
        end
    endtask

    // Flushes, then runs the configuration; mode 0 = clk_en high, 1 = toggling, 2 = random.
    task automatic run_case(input affine_cfg_t cfg, input int mode, input int flush_at,
                            input int max_cyc, output int nv, output int fv,
                            output int dc, output int mc, output bit flushed);
        bit v, dn, ms, en, fl;
        logic [15:0] ct;
        int tail;
        build(cfg);
        cycle(1'b1, 1'b1, v, ct, dn, ms);
        nv = 0; fv = -1; dc = -1; mc = -1; tail = 0; flushed = 0;
        for (int i = 0; i < max_cyc; i++) begin
            en = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 2 == 0) : ($urandom_range(0, 3) != 0);
            fl = (flush_at >= 0) && (nv == flush_at) && en && !m_done && (m_c == m_t[m_p]);
            cycle(en, fl, v, ct, dn, ms);
            if (fl) begin
                flushed = 1;
                break;
            end
            if (v) begin
                nv++;
                if (fv < 0) fv = int'(ct);
            end
            if (ms && mc < 0) mc = int'(ct);
            if (dn) begin
                if (dc < 0) dc = int'(ct);
                tail++;
                if (tail == 3) break;
            end
        end
    endtask

    initial begin
        affine_cfg_t c2d, cfg;
        int nv, fv, dc, mc;
        bit fl_done;
        logic [95:0] e_idx;

        clk = 0; rst_n = 0; clk_en = 0; flush = 0;
        n_tests = 0; n_fail = 0;

        c2d = '0;
        c2d.dims = 3'd2;
        c2d.ranges[15:0] = 16'd5;  c2d.ranges[31:16] = 16'd6;
        c2d.strides[15:0] = 16'd2; c2d.strides[31:16] = 16'd11;
        c2d.start = 16'd10;
        build(c2d);
        m_reset();
        #12;
        chk("rst_cycle", 96'(cycle_time), 96'(0));
        chk("rst_sched", 96'(sched_time), 96'(10));
        chk("rst_idx",   iter_idx,        96'(0));
        chk("rst_done",  96'(done),       96'(0));
        chk("rst_miss",  96'(sched_miss), 96'(0));
        chk("rst_valid", 96'(valid),      96'(0));
        @(negedge clk);
        rst_n = 1;

        run_case(c2d, 0, -1, 200, nv, fv, dc, mc, fl_done);
        e_idx = '0; e_idx[15:0] = 16'd4; e_idx[31:16] = 16'd5;
        chk("2d_count", 96'(nv), 96'(30));
        chk("2d_first", 96'(fv), 96'(10));
        chk("2d_done",  96'(dc), 96'(74));
        chk("2d_miss",  96'(mc), 96'(-1));
        chk("2d_idx",   iter_idx, e_idx);

        cfg = '0;
        cfg.dims = 3'd3;
        cfg.ranges[15:0] = 16'd2;  cfg.ranges[31:16] = 16'd3;  cfg.ranges[47:32] = 16'd4;
        cfg.strides[15:0] = 16'd1; cfg.strides[31:16] = 16'd2; cfg.strides[47:32] = 16'd6;
        run_case(cfg, 0, -1, 100, nv, fv, dc, mc, fl_done);
        chk("3d_count", 96'(nv), 96'(24));
        chk("3d_first", 96'(fv), 96'(0));
        chk("3d_done",  96'(dc), 96'(24));

        run_case(c2d, 1, -1, 400, nv, fv, dc, mc, fl_done);
        chk("en_count", 96'(nv), 96'(30));
        chk("en_done",  96'(dc), 96'(74));

        run_case(c2d, 0, 7, 200, nv, fv, dc, mc, fl_done);
        chk("fl_hit",   96'(fl_done), 96'(1));
        chk("fl_count", 96'(nv),      96'(7));
        cfg = c2d;
        cfg.start = 16'd3;
        run_case(cfg, 0, -1, 200, nv, fv, dc, mc, fl_done);
        chk("fl_first", 96'(fv), 96'(3));
        chk("fl_total", 96'(nv), 96'(30));
        chk("fl_done",  96'(dc), 96'(67));

        cfg = '0;
        cfg.start = 16'd5;
        cfg.ranges[31:16] = 16'd4;
        run_case(cfg, 0, -1, 50, nv, fv, dc, mc, fl_done);
        chk("bnd_count", 96'(nv), 96'(1));
        chk("bnd_first", 96'(fv), 96'(5));
        chk("bnd_done",  96'(dc), 96'(6));

        cfg = '0;
        cfg.dims = 3'd1;
        cfg.ranges[15:0] = 16'd3;
        run_case(cfg, 0, -1, 50, nv, fv, dc, mc, fl_done);
        chk("zs_count", 96'(nv), 96'(3));
        chk("zs_miss",  96'(mc), 96'(2));
        chk("zs_done",  96'(dc), 96'(3));

        cfg.ranges[15:0] = 16'd20;
        cfg.start = 16'd9;
        run_case(cfg, 0, -1, 14, nv, fv, dc, mc, fl_done);
        chk("ar_pre_miss", 96'(sched_miss), 96'(1));
        @(negedge clk);
        clk_en = 0;
        #2 rst_n = 0;
        #1;
        chk("ar_cycle", 96'(cycle_time), 96'(0));
        chk("ar_sched", 96'(sched_time), 96'(9));
        chk("ar_idx",   iter_idx,        96'(0));
        chk("ar_done",  96'(done),       96'(0));
        chk("ar_miss",  96'(sched_miss), 96'(0));
        chk("ar_valid", 96'(valid),      96'(0));
        m_reset();
        @(negedge clk);
        rst_n = 1;

        for (int r = 0; r < 10; r++) begin
            cfg = '0;
            cfg.dims = 3'($urandom_range(0, 7));
            for (int k = 0; k < 6; k++) begin
                cfg.ranges[k*16 +: 16]  = 16'($urandom_range(0, 3));
                cfg.strides[k*16 +: 16] = 16'($urandom_range(0, 6));
            end
            cfg.start = 16'($urandom_range(0, 15));
            run_case(cfg, 2, -1, 120, nv, fv, dc, mc, fl_done);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
